// File: rtl/sd_spi_response_rx.sv
// sd_spi_response_rx: SD SPI-mode response and block receiver.
// Samples MISO on sck rise; decodes R1, R3/R7 and single data blocks.
module sd_spi_response_rx #(
  parameter int NCR_MAX       = 8,
  parameter int TOKEN_TIMEOUT = 1024,
  parameter int BLOCK_LEN     = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_miso,
  input  logic        start,
  input  logic [1:0]  resp_type,
  output logic        busy,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic [7:0]  data_byte,
  output logic        data_valid,
  output logic        done,
  output logic        timeout,
  output logic        token_err,
  output logic        crc_err
);

  localparam int NCR_BITS = NCR_MAX * 8;
  localparam int NW = $clog2(NCR_BITS) + 1;
  localparam int TW = $clog2(TOKEN_TIMEOUT) + 1;
  localparam int BW = $clog2(BLOCK_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_R1,
    S_R1,
    S_EXT,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic          sck_q;
  logic          rise;
  logic [1:0]    r_type;
  logic [NW-1:0] wait_cnt;
  logic [TW-1:0] tok_cnt;
  logic [BW-1:0] byte_cnt;
  logic [5:0]    bit_cnt;
  logic [15:0]   sh;
  logic [15:0]   crc;
  logic [7:0]    byte_n;
  logic [15:0]   word_n;
  logic [15:0]   crc_n;
  logic          byte_end;
  logic          ncr_last;
  logic          tok_last;
  logic          blk_last;

  assign rise     = spi_sck & ~sck_q;
  assign byte_n   = {sh[6:0], spi_miso};
  assign word_n   = {sh[14:0], spi_miso};
  assign crc_n    = {crc[14:0], 1'b0}
                  ^ ((crc[15] ^ spi_miso) ? 16'h1021 : 16'h0000);
  assign byte_end = (bit_cnt[2:0] == 3'd7);
  assign ncr_last = (wait_cnt == NW'(NCR_BITS - 1));
  assign tok_last = (tok_cnt == TW'(TOKEN_TIMEOUT - 1));
  assign blk_last = (byte_cnt == BW'(BLOCK_LEN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode plus busy/done outputs.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_WAIT_R1;
      end
      S_WAIT_R1: begin
        busy = 1'b1;
        if (rise) begin
          if (!spi_miso)     state_n = S_R1;
          else if (ncr_last) state_n = S_DONE;
        end
      end
      S_R1: begin
        busy = 1'b1;
        if (rise && byte_end) begin
          unique case (1'b1)
            (r_type == 2'd1):
              state_n = S_EXT;
            (r_type == 2'd2) && (byte_n == 8'h00):
              state_n = S_TOKEN;
            default:
              state_n = S_DONE;
          endcase
        end
      end
      S_EXT: begin
        busy = 1'b1;
        if (rise && bit_cnt == 6'd31) state_n = S_DONE;
      end
      S_TOKEN: begin
        busy = 1'b1;
        if (rise && byte_end) begin
          if (byte_n == 8'hFE)
            state_n = S_DATA;
          else if (byte_n[7:5] == 3'b000 || tok_last)
            state_n = S_DONE;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (rise && byte_end && blk_last) state_n = S_CRC;
      end
      S_CRC: begin
        busy = 1'b1;
        if (rise && bit_cnt == 6'd15) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bit shifting, counters, CRC and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q      <= 1'b0;
      r_type     <= 2'd0;
      wait_cnt   <= '0;
      tok_cnt    <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      crc        <= '0;
      resp_r1    <= 8'hFF;
      resp_ext   <= '0;
      data_byte  <= '0;
      data_valid <= 1'b0;
      timeout    <= 1'b0;
      token_err  <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      sck_q      <= spi_sck;
      data_valid <= 1'b0;
      if (state == S_IDLE && start) begin
        r_type    <= resp_type;
        wait_cnt  <= '0;
        tok_cnt   <= '0;
        byte_cnt  <= '0;
        bit_cnt   <= '0;
        sh        <= '0;
        crc       <= '0;
        resp_r1   <= 8'hFF;
        resp_ext  <= '0;
        timeout   <= 1'b0;
        token_err <= 1'b0;
        crc_err   <= 1'b0;
      end else if (rise) begin
        case (state)
          S_WAIT_R1: begin
            if (!spi_miso) begin
              sh      <= word_n;
              bit_cnt <= 6'd1;
            end else begin
              wait_cnt <= wait_cnt + NW'(1);
              if (ncr_last) timeout <= 1'b1;
            end
          end
          S_R1: begin
            sh <= word_n;
            if (byte_end) begin
              resp_r1 <= byte_n;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_EXT: begin
            resp_ext <= {resp_ext[30:0], spi_miso};
            bit_cnt  <= bit_cnt + 6'd1;
          end
          S_TOKEN: begin
            sh <= word_n;
            if (byte_end) begin
              bit_cnt <= '0;
              if (byte_n == 8'hFE) begin
                crc <= '0;
              end else if (byte_n[7:5] == 3'b000) begin
                token_err <= 1'b1;
              end else begin
                tok_cnt <= tok_cnt + TW'(1);
                if (tok_last) timeout <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_DATA: begin
            sh  <= word_n;
            crc <= crc_n;
            if (byte_end) begin
              bit_cnt    <= '0;
              data_byte  <= byte_n;
              data_valid <= 1'b1;
              byte_cnt   <= byte_cnt + BW'(1);
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_CRC: begin
            sh      <= word_n;
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd15) crc_err <= (word_n != crc);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_response_rx.sv
// tb_sd_spi_response_rx: random + directed bench for sd_spi_response_rx.
// Expected results come from a byte-level parse of the MISO stream.
module tb_sd_spi_response_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck;
  logic        spi_miso;
  logic        start;
  logic [1:0]  resp_type;
  logic        busy;
  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;
  logic [7:0]  data_byte;
  logic        data_valid;
  logic        done;
  logic        timeout;
  logic        token_err;
  logic        crc_err;

  int checks = 0;
  int errors = 0;

  bit         bits[$];
  logic [7:0] exp_data[$];
  int         m_end;
  logic [7:0] m_r1;
  logic [31:0] m_ext;
  bit         m_tmo, m_tok, m_crc;

  int rises;
  bit txn_active;
  bit done_seen;
  int rx_idx;
  int done_rise;

  sd_spi_response_rx dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_miso   (spi_miso),
    .start      (start),
    .resp_type  (resp_type),
    .busy       (busy),
    .resp_r1    (resp_r1),
    .resp_ext   (resp_ext),
    .data_byte  (data_byte),
    .data_valid (data_valid),
    .done       (done),
    .timeout    (timeout),
    .token_err  (token_err),
    .crc_err    (crc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                           input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic bit bit_at(input int p);
    return (p < bits.size()) ? bits[p] : 1'b1;
  endfunction

  function automatic logic [7:0] get_byte(input int p);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++) b = {b[6:0], bit_at(p + k)};
    return b;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) bits.push_back(b[k]);
  endtask

  task automatic push_ones(input int n);
    for (int k = 0; k < n; k++) bits.push_back(1'b1);
  endtask

  // Parse the whole stream into the results a card link must produce.
  task automatic model(input logic [1:0] ty);
    int p;
    int k;
    logic [7:0] b;
    logic [15:0] c;
    logic [15:0] rx;
    m_tmo = 0; m_tok = 0; m_crc = 0;
    m_r1 = 8'hFF; m_ext = 32'h0;
    exp_data.delete();
    p = 0;
    while (p < 64 && bit_at(p)) p++;
    if (p == 64) begin
      m_tmo = 1;
      m_end = 64;
      return;
    end
    m_r1 = get_byte(p);
    p += 8;
    if (ty == 2'd1) begin
      m_ext = {get_byte(p), get_byte(p + 8),
               get_byte(p + 16), get_byte(p + 24)};
      p += 32;
    end else if (ty == 2'd2 && m_r1 == 8'h00) begin
      b = 8'hFF;
      for (k = 0; k < 1024; k++) begin
        b = get_byte(p);
        p += 8;
        if (b == 8'hFE || b[7:5] == 3'b000) break;
      end
      if (k == 1024) begin
        m_tmo = 1;
      end else if (b != 8'hFE) begin
        m_tok = 1;
      end else begin
        c = 16'h0;
        for (int j = 0; j < 512; j++) begin
          b = get_byte(p);
          p += 8;
          exp_data.push_back(b);
          c = crc_byte(c, b);
        end
        rx = {get_byte(p), get_byte(p + 8)};
        p += 16;
        m_crc = (rx != c);
      end
    end
    m_end = p;
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (data_valid) begin
          if (!txn_active || rx_idx >= exp_data.size()) begin
            checks++;
            errors++;
            $display("FAIL stray_data_valid actual=%h required=none",
                     data_byte);
          end else begin
            chk("data_byte", data_byte, exp_data[rx_idx]);
            rx_idx++;
          end
        end
        if (txn_active && done) begin
          chk("done_busy", busy, 0);
          chk("done_rise", rises, m_end);
          chk("r1", resp_r1, m_r1);
          chk("ext", resp_ext, m_ext);
          chk("timeout", timeout, m_tmo);
          chk("token_err", token_err, m_tok);
          chk("crc_err", crc_err, m_crc);
          chk("data_count", rx_idx, exp_data.size());
          done_rise  = rises;
          done_seen  = 1;
          txn_active = 0;
        end else if (txn_active) begin
          chk("busy_active", busy, 1);
        end else begin
          chk("idle_done", done, 0);
          chk("idle_busy", busy, 0);
        end
      end
    end
  endtask

  // nbits < 0: drive the whole expected transaction and wait for done.
  task automatic run_txn(input logic [1:0] ty, input int nbits,
                         input bit poke);
    int lim;
    int poke_at;
    model(ty);
    lim = (nbits < 0) ? m_end : nbits;
    poke_at = poke ? int'($urandom_range(0, m_end - 2)) : -1;
    @(negedge clk);
    spi_sck = 0;
    start = 1;
    resp_type = ty;
    rises = 0;
    rx_idx = 0;
    done_seen = 0;
    done_rise = -1;
    txn_active = 1;
    @(negedge clk);
    start = 0;
    resp_type = 2'($urandom);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      spi_sck = 0;
      spi_miso = bits[i];
      start = 0;
      @(negedge clk);
      spi_sck = 1;
      rises = i + 1;
      if (i == poke_at) begin
        start = 1;
        resp_type = 2'($urandom);
      end
    end
    @(negedge clk);
    spi_sck = 0;
    start = 0;
    spi_miso = 1;
    if (nbits < 0) begin
      for (int w = 0; w < 8 && !done_seen; w++) @(negedge clk);
      if (!done_seen) begin
        checks++;
        errors++;
        $display("FAIL done_missing actual=none required=rise %0d", m_end);
        txn_active = 0;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_r1"}, resp_r1, 8'hFF);
    chk({tag, "_ext"}, resp_ext, 32'h0);
    chk({tag, "_dbyte"}, data_byte, 8'h00);
    chk({tag, "_dvalid"}, data_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tmo"}, timeout, 0);
    chk({tag, "_tok"}, token_err, 0);
    chk({tag, "_crc"}, crc_err, 0);
  endtask

  task automatic build_block(input logic [15:0] crc_xor);
    logic [15:0] c;
    bits.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'hFF);
    push_byte(8'hFE);
    c = 16'h0;
    for (int i = 0; i < 512; i++) begin
      push_byte(8'(i));
      c = crc_byte(c, 8'(i));
    end
    c = c ^ crc_xor;
    push_byte(c[15:8]);
    push_byte(c[7:0]);
  endtask

  initial begin
    logic [15:0] pin;
    logic [1:0]  ty;
    logic [7:0]  r1;
    rst = 1; spi_sck = 0; spi_miso = 1;
    start = 0; resp_type = 2'd0;
    txn_active = 0; done_seen = 0;
    rises = 0; rx_idx = 0; done_rise = -1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_reset("rst0");

    pin = 16'h0;
    for (int i = 0; i < 9; i++) pin = crc_byte(pin, 8'(8'h31 + i));
    chk("crc_pin", pin, 16'h31C3);

    bits.delete();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFF);
    push_byte(8'h01);
    run_txn(2'd0, -1, 0);
    chk("r1only_r1", resp_r1, 8'h01);
    chk("r1only_rise", done_rise, 32);
    chk("r1only_tmo", timeout, 0);

    bits.delete();
    push_byte(8'hFF); push_byte(8'h01);
    push_byte(8'h00); push_byte(8'h00);
    push_byte(8'h01); push_byte(8'hAA);
    run_txn(2'd1, -1, 0);
    chk("r7_r1", resp_r1, 8'h01);
    chk("r7_ext", resp_ext, 32'h000001AA);

    bits.delete();
    push_ones(80);
    run_txn(2'd0, -1, 0);
    chk("ncr_rise", done_rise, 64);
    chk("ncr_tmo", timeout, 1);
    chk("ncr_r1", resp_r1, 8'hFF);

    bits.delete();
    push_ones(63);
    push_byte(8'h05);
    run_txn(2'd3, -1, 0);
    chk("ncr63_tmo", timeout, 0);
    chk("ncr63_r1", resp_r1, 8'h05);
    chk("ncr63_rise", done_rise, 71);

    build_block(16'h0000);
    run_txn(2'd2, -1, 0);
    chk("blk_crc", crc_err, 0);
    chk("blk_count", rx_idx, 512);

    build_block(16'h0001);
    run_txn(2'd2, -1, 0);
    chk("blkbad_crc", crc_err, 1);
    chk("blkbad_count", rx_idx, 512);

    bits.delete();
    push_byte(8'h00);
    push_byte(8'h09);
    run_txn(2'd2, -1, 0);
    chk("tokerr_flag", token_err, 1);
    chk("tokerr_count", rx_idx, 0);
    chk("tokerr_tmo", timeout, 0);

    bits.delete();
    push_byte(8'h00);
    push_ones(8 * 1024);
    push_byte(8'hFE);
    run_txn(2'd2, -1, 0);
    chk("toktmo_flag", timeout, 1);
    chk("toktmo_rise", done_rise, 8 + 8192);

    build_block(16'h0000);
    run_txn(2'd2, 32 + 800 + 3, 0);
    rst = 1;
    txn_active = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_reset("midrst");
    bits.delete();
    push_byte(8'hFF);
    push_byte(8'h00);
    run_txn(2'd0, -1, 0);
    chk("postrst_r1", resp_r1, 8'h00);
    chk("postrst_rise", done_rise, 16);

    for (int t = 0; t < 30; t++) begin
      bits.delete();
      push_ones($urandom_range(0, 70));
      ty = 2'($urandom);
      r1 = 8'($urandom_range(0, 127));
      if (ty == 2'd2 && $urandom_range(0, 1) == 1) r1 = 8'h00;
      push_byte(r1);
      if (ty == 2'd1) begin
        for (int k = 0; k < 4; k++) push_byte(8'($urandom));
      end
      if (ty == 2'd2 && r1 == 8'h00) begin
        for (int k = 0; k < int'($urandom_range(0, 5)); k++)
          push_byte(8'($urandom_range(32, 253)));
        push_byte(8'($urandom_range(0, 31)));
      end
      run_txn(ty, -1, $urandom_range(0, 1) == 1);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
